// File: rtl/lns_pkg.sv
// Shared LNS definitions: operand format, saturation helper and the
// sb/db correction tables (log2(1 +/- 2^-t) in 1/128 units, t = i/8).
// Also used by the LNS multiplier and conversion blocks.
package lns_pkg;

  localparam int MAG_W     = 11;
  localparam int FRAC_W    = 7;
  localparam int SEG_SHIFT = 4;
  // Correction is below half an LSB beyond 10 octaves of separation.
  localparam int D_MAX     = 10 << FRAC_W;
  localparam int N_SEG     = D_MAX >> SEG_SHIFT;
  localparam int SEG_W     = $clog2(N_SEG + 1);

  localparam logic signed [MAG_W-1:0] ZERO_MAG = {1'b1, {(MAG_W-1){1'b0}}};
  localparam logic signed [MAG_W-1:0] MAG_MAX  = {1'b0, {(MAG_W-1){1'b1}}};

  typedef struct packed {
    logic                    sign;
    logic signed [MAG_W-1:0] mag;
  } lns_t;

  typedef logic        [MAG_W:0]   d_t;
  typedef logic signed [MAG_W:0]   corr_t;
  typedef logic signed [MAG_W+1:0] wide_t;

  // round(log2(1 + 2^-(i/8)) * 128); entry 0 is exactly 2x.
  localparam int SB_TAB [N_SEG] = '{
    128, 120, 113, 106,  99,  92,  86,  80,
     75,  70,  65,  60,  56,  52,  48,  45,
     41,  38,  35,  33,  30,  28,  26,  24,
     22,  20,  18,  17,  16,  14,  13,  12,
     11,  10,   9,   9,   8,   7,   7,   6,
      6,   5,   5,   4,   4,   4,   3,   3,
      3,   3,   2,   2,   2,   2,   2,   2,
      1,   1,   1,   1,   1,   1,   1,   1,
      1,   1,   1,   1,   1,   0,   0,   0,
      0,   0,   0,   0,   0,   0,   0,   0
  };

  // round(log2(1 - 2^-(i/8)) * 128); entry 0 is the singular point, clamped.
  localparam int DB_TAB [N_SEG] = '{
    -1024, -460, -339, -272, -227, -193, -167, -146,
     -128, -113, -101,  -90,  -81,  -72,  -65,  -59,
      -53,  -48,  -44,  -40,  -36,  -33,  -30,  -27,
      -25,  -22,  -21,  -19,  -17,  -16,  -14,  -13,
      -12,  -11,  -10,   -9,   -8,   -8,   -7,   -6,
       -6,   -5,   -5,   -5,   -4,   -4,   -3,   -3,
       -3,   -3,   -2,   -2,   -2,   -2,   -2,   -2,
       -1,   -1,   -1,   -1,   -1,   -1,   -1,   -1,
       -1,   -1,   -1,   -1,   -1,    0,    0,    0,
        0,    0,    0,    0,    0,    0,    0,    0
  };

  // Table entry for segment seg; segments at or past D_MAX read as 0.
  function automatic corr_t phi_entry(input logic sub, input logic [SEG_W-1:0] seg);
    corr_t e;
    e = '0;
    if (int'(seg) < N_SEG) e = sub ? corr_t'(DB_TAB[seg]) : corr_t'(SB_TAB[seg]);
    return e;
  endfunction

  // Clamp a widened log magnitude into the representable range.
  function automatic logic signed [MAG_W-1:0] sat_mag(input wide_t r);
    if (r > wide_t'(MAG_MAX)) return MAG_MAX;
    if (r < wide_t'(ZERO_MAG)) return ZERO_MAG;
    return r[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/lns_phi_lut.sv
// Gaussian-log correction for LNS add/subtract.
// Default: nearest-lower segment lookup. With LNS_ADDER_INTERP_EN defined,
// linear interpolation between adjacent entries, rounded to nearest.
module lns_phi_lut
  import lns_pkg::*;
(
  input  logic [MAG_W:0]        i_d,
  input  logic                  i_op,
  output logic signed [MAG_W:0] o_corr
);

  logic [SEG_W-1:0] w_seg;
  logic             w_far;

  assign w_seg = i_d[SEG_SHIFT +: SEG_W];
  assign w_far = (i_d >= d_t'(D_MAX));

`ifdef LNS_ADDER_INTERP_EN
  typedef logic signed [MAG_W+6:0] prod_t;

  corr_t                 w_e0;
  corr_t                 w_e1;
  wide_t                 w_delta;
  prod_t                 w_prod;
  logic [SEG_SHIFT-1:0]  w_frac;

  // Interpolate between entry[seg] and entry[seg+1]; +half LSB before the shift rounds to nearest.
  always_comb begin
    w_e0    = phi_entry(i_op, w_seg);
    w_e1    = phi_entry(i_op, w_seg + SEG_W'(1));
    w_frac  = i_d[SEG_SHIFT-1:0];
    w_delta = wide_t'(w_e1) - wide_t'(w_e0);
    w_prod  = prod_t'(w_delta) * prod_t'($signed({1'b0, w_frac}))
            + prod_t'(1 << (SEG_SHIFT - 1));
    o_corr  = '0;
    if (!w_far) o_corr = w_e0 + corr_t'(w_prod >>> SEG_SHIFT);
  end
`else
  // Nearest-lower segment lookup.
  always_comb begin
    o_corr = '0;
    if (!w_far) o_corr = phi_entry(i_op, w_seg);
  end
`endif

endmodule

// File: rtl/lns_adder.sv
// Signed LNS adder, one result per cycle, latency 1.
// Optional interpolated correction: define LNS_ADDER_INTERP_EN.
module lns_adder
  import lns_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [MAG_W:0] x,
  input  logic [MAG_W:0] y,
  output logic           out_valid,
  output logic [MAG_W:0] out
);

  lns_t  w_x;
  lns_t  w_y;
  lns_t  w_big;
  logic  w_x_big;
  logic  w_sub;
  logic  w_cancel;
  corr_t w_diff;
  d_t    w_d;
  corr_t w_corr;
  wide_t w_sum;
  lns_t  w_res;
  lns_t  r_out;
  logic  r_valid;

  assign w_x = x;
  assign w_y = y;

  // Pick the larger-magnitude operand (tie keeps x) and form |x.mag - y.mag|.
  always_comb begin
    w_x_big = (w_x.mag >= w_y.mag);
    w_big   = w_x_big ? w_x : w_y;
    w_diff  = corr_t'(w_x.mag) - corr_t'(w_y.mag);
    w_d     = w_x_big ? d_t'(w_diff) : d_t'(-w_diff);
    w_sub   = w_x.sign ^ w_y.sign;
  end

  lns_phi_lut u_phi (
    .i_d    (w_d),
    .i_op   (w_sub),
    .o_corr (w_corr)
  );

  // Apply correction, saturate, and substitute the ZERO code on exact cancellation.
  always_comb begin
    w_sum     = wide_t'(w_big.mag) + wide_t'(w_corr);
    w_cancel  = w_sub && (w_d == '0);
    w_res     = '0;
    w_res.sign = w_big.sign;
    w_res.mag  = sat_mag(w_sum);
    if (w_cancel) begin
      w_res.sign = 1'b0;
      w_res.mag  = ZERO_MAG;
    end
  end

  // Output register: result captured only on valid input, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_out <= w_res;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_lns_adder.sv
// Self-checking bench for lns_adder: directed cases, a signed sweep and
// random traffic against a real-arithmetic reference model.
module tb_lns_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [11:0] x;
  logic [11:0] y;
  logic        out_valid;
  logic [11:0] out;

  logic [11:0] exp_out;
  logic        exp_valid;
  int          tests;
  int          fails;

  lns_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table entry straight from the definition: round(log2(1 +/- 2^-(i/8)) * 128).
  function automatic int tab_ref(bit sub, int i);
    real p;
    real v;
    if (i >= 80) return 0;
    if (sub && i == 0) return -1024;
    p = $pow(2.0, -real'(i) / 8.0);
    v = (sub ? $ln(1.0 - p) : $ln(1.0 + p)) / $ln(2.0) * 128.0;
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int phi_ref(bit sub, int d);
    int e0;
`ifdef LNS_ADDER_INTERP_EN
    int e1;
    int f;
`endif
    if (d >= 1280) return 0;
    e0 = tab_ref(sub, d / 16);
`ifdef LNS_ADDER_INTERP_EN
    e1 = tab_ref(sub, d / 16 + 1);
    f  = d % 16;
    return e0 + $rtoi($floor(real'((e1 - e0) * f) / 16.0 + 0.5));
`else
    return e0;
`endif
  endfunction

  function automatic logic [11:0] add_ref(logic [11:0] a, logic [11:0] b);
    int am;
    int bm;
    int bigm;
    int d;
    int r;
    bit bigs;
    bit sub;
    am = int'($signed(a[10:0]));
    bm = int'($signed(b[10:0]));
    if (am >= bm) begin
      bigm = am; bigs = a[11];
    end else begin
      bigm = bm; bigs = b[11];
    end
    d   = (am > bm) ? am - bm : bm - am;
    sub = (a[11] != b[11]);
    if (sub && d == 0) return 12'h400;
    r = bigm + phi_ref(sub, d);
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
    return {bigs, r[10:0]};
  endfunction

  task automatic drive(input logic v, input logic [11:0] a, input logic [11:0] b);
    in_valid  = v;
    x         = a;
    y         = b;
    exp_valid = v;
    if (v) exp_out = add_ref(a, b);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] want_o, input logic want_v);
    tests++;
    assert (out_valid === want_v) else begin
      fails++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, want_v);
    end
    tests++;
    assert (out === want_o) else begin
      fails++;
      $error("FAIL %s out: observed %h expected %h (x=%h y=%h)", tag, out, want_o, x, y);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    x         = 12'h000;
    y         = 12'h000;
    exp_out   = 12'h000;
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 12'h000, 1'b0);
    rst = 1'b0;

    drive(1'b1, 12'h000, 12'h000); check("one_plus_one",    12'h080, 1'b1);
    drive(1'b1, 12'h000, 12'h800); check("cancel_zero",     12'h400, 1'b1);
    drive(1'b1, 12'h080, 12'h800); check("two_minus_one",   12'h000, 1'b1);
    drive(1'b1, 12'h800, 12'h080); check("swapped",         12'h000, 1'b1);
    drive(1'b1, 12'h880, 12'h000); check("neg_two_plus_one",12'h800, 1'b1);
    drive(1'b1, 12'h3FF, 12'h3FF); check("sat_high",        12'h3FF, 1'b1);
    drive(1'b1, 12'h000, 12'h400); check("d_1024",          12'h001, 1'b1);
    drive(1'b1, 12'h12C, 12'h418); check("d_past_dmax",     12'h12C, 1'b1);
    drive(1'b0, 12'h0AB, 12'h9CD); check("hold",            12'h12C, 1'b0);
    drive(1'b1, 12'h400, 12'hC04); check("sat_low",         12'hC00, 1'b1);

    for (int xm = -16; xm <= 15; xm++) begin
      for (int ym = -16; ym <= 15; ym++) begin
        drive(1'b1, {1'b0, 11'(xm)}, {1'b1, 11'(ym)});
        check("sweep", exp_out, exp_valid);
      end
    end

    drive(1'b1, 12'(32'($urandom)), 12'(32'($urandom)));
    check("pre_rst", exp_out, exp_valid);
    rst      = 1'b1;
    in_valid = 1'b1;
    x        = 12'h080;
    y        = 12'h080;
    @(posedge clk);
    #1;
    exp_out   = 12'h000;
    exp_valid = 1'b0;
    check("rst_mid", 12'h000, 1'b0);
    rst = 1'b0;
    drive(1'b1, 12'h000, 12'h000); check("post_rst", 12'h080, 1'b1);

    for (int unsigned n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 12'(32'($urandom)), 12'(32'($urandom)));
      check("rand", exp_out, exp_valid);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
